// File: rtl/add_share_arb_pkg.sv
// Shared types and constants for the add_share_arb adder-sharing arbiter.
package add_share_arb_pkg;

  localparam int ADD_W   = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Next round-robin position after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/add_share_arb_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
// Produces both a one-hot grant and the binary index of the winner.
module add_share_arb_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx
);

  // Scan distances 0..NUM_REQ-1 from ptr; the nearest valid requester wins.
  always_comb begin
    logic found;
    found     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && valid[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/adder_16bit.sv
// Plain 16-bit ripple adder with carry-in and carry-out; the shared resource.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        co
);

  assign {co, y} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: one adder_16bit shared among NUM_REQ requesters with
// round-robin arbitration and a single registered result stage.
// Multi-beat chained adds lock the grant to their owner and forward the
// carry-out of each beat as the carry-in of the next.
// Optional build macro ADD_SHARE_ARB_OVF_EN adds the rsp_ovf output
// (signed overflow of each beat, registered alongside rsp_y).
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_y,
  output logic                     rsp_co,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_last
`ifdef ADD_SHARE_ARB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  // Arbitration / chain state
  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              carry_q, carry_d;

  // Result register
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADD_W-1:0]  rsp_y_q, rsp_y_d;
  logic              rsp_co_q, rsp_co_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_last_q, rsp_last_d;
`ifdef ADD_SHARE_ARB_OVF_EN
  logic              rsp_ovf_q, rsp_ovf_d;
`endif

  // Grant and datapath nets
  logic [NUM_REQ-1:0] pick_oh, owner_oh, grant_oh;
  logic [ID_W-1:0]    pick_idx, grant_idx;
  logic               slot_free, xfer;
  logic [ADD_W-1:0]   op_a, op_b, sum_y;
  logic               cin_sel, op_cin, op_last, sum_co;

  add_share_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  // Grant source: round-robin picker while idle, the chain owner while locked.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) owner_oh[i] = 1'b1;
    end
    grant_oh  = (state_q == LOCKED) ? owner_oh : pick_oh;
    grant_idx = (state_q == LOCKED) ? owner_q  : pick_idx;
  end

  // A beat can only be taken when the result register is empty or draining.
  // Reset also forces ready low, since the grant logic alone would not.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign req_ready = (rst || !slot_free) ? '0 : (grant_oh & req_valid);
  assign xfer      = |req_ready;

  // Operand mux onto the shared adder; chained beats take the stored carry.
  always_comb begin
    op_a    = '0;
    op_b    = '0;
    cin_sel = 1'b0;
    op_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_a    = req_a[i*ADD_W +: ADD_W];
        op_b    = req_b[i*ADD_W +: ADD_W];
        cin_sel = req_cin[i];
        op_last = req_last[i];
      end
    end
    op_cin = (state_q == LOCKED) ? carry_q : cin_sel;
  end

  adder_16bit u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .y   (sum_y),
    .co  (sum_co)
  );

  // Next state: capture a beat on transfer, otherwise drain or hold the result.
  // Carry and FSM only move on a transfer, so consumer stalls leave them intact.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_co_d    = rsp_co_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;
`ifdef ADD_SHARE_ARB_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = sum_y;
      rsp_co_d    = sum_co;
      rsp_id_d    = grant_idx;
      rsp_last_d  = op_last;
`ifdef ADD_SHARE_ARB_OVF_EN
      rsp_ovf_d   = (op_a[ADD_W-1] == op_b[ADD_W-1]) && (sum_y[ADD_W-1] != op_a[ADD_W-1]);
`endif
      carry_d     = sum_co;
      if (op_last) begin
        state_d = IDLE;
        ptr_d   = ID_W'(rr_next(32'(grant_idx), NUM_REQ));
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // FSM and result register; reset abandons any chain in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_co_q    <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
`ifdef ADD_SHARE_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_co_q    <= rsp_co_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
`ifdef ADD_SHARE_ARB_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;
`ifdef ADD_SHARE_ARB_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Testbench for add_share_arb: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_add_share_arb;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*16-1:0]   req_a = '0;
  logic [N*16-1:0]   req_b = '0;
  logic [N-1:0]      req_cin = '0;
  logic [N-1:0]      req_last = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [15:0]       rsp_y;
  logic              rsp_co;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_last;
`ifdef ADD_SHARE_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  add_share_arb #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_co    (rsp_co),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
`ifdef ADD_SHARE_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic last);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = cin;
    req_last[i]       = last;
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1 rst = 1'b1;
    #1;
    outs = {rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last};
`ifdef ADD_SHARE_ARB_OVF_EN
    n_checks++;
    if (rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", rsp_ovf); end
`endif
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== {1'b1, 16'h0000, 1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b y=%h co=%b id=%0d last=%b want v=1 y=0000 co=1 id=0 last=1",
               rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] eid;
    logic [15:0]    ey;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 16'(i * 4369), 16'(i + 1), 1'b0, 1'b1);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      eid = IDW'(k % N);
      ey  = 16'((k % N) * 4369 + (k % N) + 1);
      #1;
      n_checks++;
      if (req_ready !== (N'(1) << (k % N))) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want one-hot %0d", k, req_ready, k % N);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_y !== ey) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%0d y=%h want v=1 id=%0d y=%h", k, rsp_valid, rsp_id, rsp_y, eid, ey);
      end
    end
    clear_inputs();
  endtask

  task automatic test_chain();
    do_reset();
    rsp_ready = 1'b1;
    // one beat from req1 moves the pointer to 2
    set_req(1, 16'd5, 16'd6, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    // first chain beat from req2 while req1 stays valid
    set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    req_valid = 4'b0110;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL chain_ready0: got %b want 0100", req_ready); end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== {1'b1, 16'h0000, 1'b1, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL chain_beat0: got v=%b y=%h co=%b id=%0d last=%b want v=1 y=0000 co=1 id=2 last=0",
               rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last);
    end
    // owner idles: nobody else may be granted
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL chain_hold: got %b want 0000", req_ready); end
    tick();
    // final chain beat uses the stored carry
    set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
    req_valid = 4'b0110;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL chain_ready1: got %b want 0100", req_ready); end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== {1'b1, 16'h0001, 1'b0, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL chain_beat1: got v=%b y=%h co=%b id=%0d last=%b want v=1 y=0001 co=0 id=2 last=1",
               rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last);
    end
    // chain over: req1 finally granted
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL chain_after: got %b want 0010", req_ready); end
    tick();
    n_checks++;
    if (rsp_id !== 2'd1 || rsp_y !== 16'd11) begin
      n_fail++; $display("FAIL chain_after_rsp: got id=%0d y=%h want id=1 y=000b", rsp_id, rsp_y);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    set_req(3, 16'h1234, 16'h4321, 1'b1, 1'b1);
    req_valid = 4'b1000;
    tick();
    rsp_ready = 1'b0;
    set_req(0, 16'h0100, 16'h0200, 1'b0, 1'b1);
    set_req(3, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== {1'b1, 16'h5556, 1'b0, 2'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b y=%h co=%b id=%0d last=%b want v=1 y=5556 co=0 id=3 last=1",
                 k, rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release: got %b want 0001", req_ready); end
    tick();
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_y !== 16'h0300) begin
      n_fail++; $display("FAIL bp_next_rsp: got id=%0d y=%h want id=0 y=0300", rsp_id, rsp_y);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int          m_ptr, m_owner, g;
    bit          m_locked, m_carry, m_valid, m_co, m_last, sf, c;
    logic [15:0] m_y, a, b;
    logic [16:0] s;
    int          m_id;
    logic [N-1:0] exp_rdy;
`ifdef ADD_SHARE_ARB_OVF_EN
    bit          m_ovf = 0;
`endif
    do_reset();
    m_ptr = 0; m_owner = 0; m_locked = 0; m_carry = 0; m_valid = 0;
    m_co = 0; m_last = 0; m_y = '0; m_id = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        set_req(i, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
      #1;
      sf = !m_valid || rsp_ready;
      g  = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (g >= 0 && sf) exp_rdy[g] = 1'b1;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, req_ready, exp_rdy);
      end
      if (exp_rdy != '0) begin
        a = req_a[16*g +: 16];
        b = req_b[16*g +: 16];
        c = m_locked ? m_carry : req_cin[g];
        s = {1'b0, a} + {1'b0, b} + 17'(c);
        m_y = s[15:0]; m_co = s[16]; m_id = g; m_last = req_last[g];
        m_valid = 1; m_carry = s[16];
`ifdef ADD_SHARE_ARB_OVF_EN
        m_ovf = (a[15] == b[15]) && (s[15] != a[15]);
`endif
        if (req_last[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
        else begin m_locked = 1; m_owner = g; end
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== {m_valid, m_y, m_co, IDW'(m_id), m_last}) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got v=%b y=%h co=%b id=%0d last=%b want v=%b y=%h co=%b id=%0d last=%b",
                 cyc, rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last, m_valid, m_y, m_co, m_id, m_last);
      end
`ifdef ADD_SHARE_ARB_OVF_EN
      n_checks++;
      if (rsp_ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", cyc, rsp_ovf, m_ovf); end
`endif
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    req_valid = 4'b0001;
    tick();
    rsp_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got v=%b y=%h co=%b id=%0d last=%b want all 0",
                         rsp_valid, rsp_y, rsp_co, rsp_id, rsp_last);
    end
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL midreset_ready: got %b want 0000", req_ready); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    rsp_ready = 1'b1;
    set_req(1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL midreset_unlock: got %b want 0010", req_ready); end
    tick();
    n_checks++;
    if (rsp_y !== 16'h0000 || rsp_co !== 1'b0 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL midreset_carry: got y=%h co=%b id=%0d want y=0000 co=0 id=1", rsp_y, rsp_co, rsp_id);
    end
    clear_inputs();
  endtask

`ifdef ADD_SHARE_ARB_OVF_EN
  task automatic test_ovf();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    req_valid = 4'b0001;
    tick();
    n_checks++;
    if (rsp_y !== 16'h8000 || rsp_ovf !== 1'b1 || rsp_co !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pos: got y=%h ovf=%b co=%b want y=8000 ovf=1 co=0", rsp_y, rsp_ovf, rsp_co);
    end
    set_req(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    n_checks++;
    if (rsp_y !== 16'h0002 || rsp_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_none: got y=%h ovf=%b want y=0002 ovf=0", rsp_y, rsp_ovf);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_chain();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef ADD_SHARE_ARB_OVF_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
